// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small TX FIFO and a polled status word.
// Define MMIO_UART_TX_PARITY_EN to add an even-parity bit (8E1 framing, status[15]=1).
module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          DEPTH        = 8,
    parameter logic [15:0] TXDATA_ADDR  = 16'h2002,
    parameter logic [15:0] STATUS_ADDR  = 16'h2004
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] memAddr,
    inout  wire  [15:0] dataBus,
    input  logic        re_L,
    input  logic        we_L,
    output logic        tx
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

`ifdef MMIO_UART_TX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
    localparam logic   PAR_FLAG   = 1'b1;
`else
    localparam state_t AFTER_DATA = STOP;
    localparam logic   PAR_FLAG   = 1'b0;
`endif

    state_t          r_state, w_next;
    logic [BW-1:0]   r_baud;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift, w_shift_n;
    logic            r_tx, w_tx_d, w_par;
    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [3:0]      r_count;
    logic            r_ovf;
    logic            w_tick, w_full, w_empty, w_wr_tx, w_wr_st, w_push, w_pop;
    logic [15:0]     w_status;
    logic            w_unused;

    assign w_tick   = r_baud == BW'(CLKS_PER_BIT - 1);
    assign w_full   = r_count == 4'(DEPTH);
    assign w_empty  = r_count == 4'd0;
    assign w_wr_tx  = !we_L && memAddr == TXDATA_ADDR;
    assign w_wr_st  = !we_L && memAddr == STATUS_ADDR;
    assign w_push   = w_wr_tx && !w_full;
    assign w_pop    = r_state == IDLE && !w_empty;
    assign w_status = {PAR_FLAG, 7'd0, r_count, r_ovf, w_full, w_empty, r_state != IDLE};
    assign dataBus  = (!re_L && memAddr == STATUS_ADDR) ? w_status : 'z;
    assign tx       = r_tx;
    assign w_unused = ^dataBus[15:8];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_empty ? IDLE : START;
            START:   w_next = w_tick ? DATA : START;
            DATA:    w_next = (w_tick && r_bit == 3'd7) ? AFTER_DATA : DATA;
            PARITY:  w_next = w_tick ? STOP : PARITY;
            STOP:    w_next = w_tick ? IDLE : STOP;
            default: w_next = IDLE;
        endcase
    end

    // tx is computed from the next state so the register changes on the same edge as the state.
    always_comb begin
        w_shift_n = w_pop ? r_mem[r_rptr] : (r_state == DATA && w_tick) ? {1'b0, r_shift[7:1]} : r_shift;
        w_tx_d    = w_next == START ? 1'b0 : w_next == DATA ? w_shift_n[0] : w_next == PARITY ? w_par : 1'b1;
    end

`ifdef MMIO_UART_TX_PARITY_EN
    logic r_par;
    always_ff @(posedge clock or posedge reset) begin
        if (reset)      r_par <= 1'b0;
        else if (w_pop) r_par <= ^r_mem[r_rptr];
    end
    assign w_par = r_par;
`else
    assign w_par = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_baud  <= (w_next != r_state || r_state == IDLE) ? '0 : r_baud + 1'b1;
            r_bit   <= w_pop ? 3'd0 : (r_state == DATA && w_tick) ? r_bit + 3'd1 : r_bit;
            r_shift <= w_shift_n;
            r_tx    <= w_tx_d;
            r_wptr  <= !w_push ? r_wptr : (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            r_rptr  <= !w_pop ? r_rptr : (r_rptr == AW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            r_count <= r_count + 4'(w_push) - 4'(w_pop);
            r_ovf   <= (w_wr_tx && w_full) ? 1'b1 : w_wr_st ? 1'b0 : r_ovf;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wptr] <= dataBus[7:0];
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed bench for mmio_uart_tx with CLKS_PER_BIT=4, DEPTH=4.
// Honours MMIO_UART_TX_PARITY_EN for framing and status[15] expectations.
module tb_mmio_uart_tx;
    localparam int N = 4;
`ifdef MMIO_UART_TX_PARITY_EN
    localparam int          NS = 11;
    localparam logic [15:0] PF = 16'h8000;
`else
    localparam int          NS = 10;
    localparam logic [15:0] PF = 16'h0000;
`endif
    localparam logic [15:0] TXA = 16'h2002;
    localparam logic [15:0] STA = 16'h2004;

    logic        clock = 1'b0;
    logic        reset, re_L, we_L, tx, tb_oe;
    logic [15:0] memAddr, tb_drive, s;
    wire  [15:0] dataBus;
    int          n_checks = 0, n_fail = 0;

    assign dataBus = tb_oe ? tb_drive : 'z;
    always #5 clock = ~clock;

    mmio_uart_tx #(.CLKS_PER_BIT(N), .DEPTH(4)) dut (
        .clock(clock), .reset(reset), .memAddr(memAddr), .dataBus(dataBus),
        .re_L(re_L), .we_L(we_L), .tx(tx)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rd_status(output logic [15:0] v);
        tb_oe = 1'b0; memAddr = STA; re_L = 1'b0;
        #1 v = dataBus;
        re_L = 1'b1; memAddr = 16'h0;
    endtask

    // The bench drives zero; any block drive on the bus would show up as non-zero.
    task automatic chk_nodrive(input string tag, input logic [15:0] a, input logic rl);
        tb_oe = 1'b1; tb_drive = 16'h0000; memAddr = a; re_L = rl;
        #1 chk(tag, dataBus, 16'h0000);
        re_L = 1'b1; tb_oe = 1'b0; memAddr = 16'h0;
    endtask

    task automatic push(input logic [7:0] b);
        memAddr = TXA; tb_oe = 1'b1; tb_drive = {8'h5A, b}; we_L = 1'b0;
        @(negedge clock);
        we_L = 1'b1; tb_oe = 1'b0; memAddr = 16'h0;
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        if (NS == 11 && j == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic run_frame(input logic [7:0] b);
        logic [15:0] v;
        for (int n = 1; n <= NS * N; n++) begin
            @(negedge clock);
            chk("frame_tx", 16'(tx), 16'(exp_bit(b, (n - 1) / N)));
        end
        rd_status(v);
        chk("frame_last_busy", v, PF | 16'h0003);
        @(negedge clock);
        rd_status(v);
        chk("frame_done_idle", v, PF | 16'h0002);
        chk("frame_done_tx", 16'(tx), 16'h0001);
    endtask

    initial begin
        int found, falls;
        logic prev;
        reset = 1'b1; re_L = 1'b1; we_L = 1'b1; memAddr = 16'h0; tb_oe = 1'b0; tb_drive = 16'h0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk("rst_tx", 16'(tx), 16'h0001);
        rd_status(s);
        chk("rst_status", s, PF | 16'h0002);
        chk_nodrive("nodrive_2000", 16'h2000, 1'b0);
        chk_nodrive("nodrive_txdata", TXA, 1'b0);
        chk_nodrive("nodrive_re_high", STA, 1'b1);

        push(8'hA5);
        chk("push_tx_still_high", 16'(tx), 16'h0001);
        rd_status(s);
        chk("push_count1", s, PF | 16'h0010);
        run_frame(8'hA5);

        memAddr = TXA; tb_oe = 1'b1; we_L = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tb_drive = 16'(i);
            @(negedge clock);
        end
        we_L = 1'b1; tb_oe = 1'b0; memAddr = 16'h0;
        rd_status(s);
        chk("ovf_status", {s[15:1], 1'b0}, PF | 16'h004C);
        chk("ovf_busy", 16'(s[0]), 16'h0001);
        memAddr = STA; tb_oe = 1'b1; tb_drive = 16'hFFFF; we_L = 1'b0;
        @(negedge clock);
        we_L = 1'b1; tb_oe = 1'b0; memAddr = 16'h0;
        rd_status(s);
        chk("ovf_clear", {s[15:1], 1'b0}, PF | 16'h0044);

        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        push(8'h00);
        repeat (18) @(negedge clock);
        chk("bit3_low", 16'(tx), 16'h0000);
        reset = 1'b1;
        #1 chk("midrst_tx", 16'(tx), 16'h0001);
        rd_status(s);
        chk("midrst_status", s, PF | 16'h0002);
        @(negedge clock);
        reset = 1'b0;
        falls = 0;
        prev = tx;
        for (int n = 0; n < 60; n++) begin
            @(negedge clock);
            if (prev && !tx) falls++;
            prev = tx;
        end
        chk("midrst_no_fall", 16'(falls), 16'h0000);

        memAddr = TXA; tb_oe = 1'b1; we_L = 1'b0; tb_drive = 16'h0000;
        @(negedge clock);
        tb_drive = 16'h00FF;
        @(negedge clock);
        we_L = 1'b1; tb_oe = 1'b0; memAddr = 16'h0;
        rd_status(s);
        chk("b2b_push_pop_count", s, PF | 16'h0011);
        chk("b2b_first_start", 16'(tx), 16'h0000);
        found = -1;
        prev = tx;
        for (int n = 2; n < 120; n++) begin
            @(negedge clock);
            if (prev && !tx) begin
                found = n;
                break;
            end
            prev = tx;
        end
        chk("b2b_start_period", 16'(found), 16'(NS * N + 2));
        for (int m = 1; m < NS * N; m++) begin
            @(negedge clock);
            chk("b2b_frame2_tx", 16'(tx), 16'(exp_bit(8'hFF, m / N)));
        end
        @(negedge clock);
        rd_status(s);
        chk("b2b_idle", s, PF | 16'h0002);

`ifdef MMIO_UART_TX_PARITY_EN
        push(8'h07);
        run_frame(8'h07);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
